// File: rtl/asic_dma_pkg.sv
// Shared AXI encodings, FSM state types and default parameters for the
// ASIC input-image DMA feeder.
package asic_dma_pkg;
    localparam int          AXI_ID_W       = 4;
    localparam int          AXI_ADDR_W     = 32;
    localparam int          AXI_DATA_W     = 32;
    localparam int          AXI_LEN_W      = 4;
    localparam logic [3:0]  AXI_ID_ZERO    = 4'h0;
    localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0]  AXI_STRB_ALL   = 4'b1111;

    localparam logic [31:0] DEF_DATA_ADDR  = 32'h0000_0004;
    localparam int          DEF_MAX_WORDS  = 1104;
    localparam int          MAX_BURST      = 16;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/asic_dma_feeder_sync_fifo.sv
// Single-clock FIFO with registered storage; reports free slots so the reader
// can reserve room for a whole burst before issuing it.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] free_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o    = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign free_cnt_o = CNT_W'(DEPTH) - count_q;
endmodule

// File: rtl/asic_dma_feeder.sv
// AXI4 master: burst-reads an image from memory and writes each word as a
// single-beat write to the ASIC wrapper's data register.
module asic_dma_feeder
    import asic_dma_pkg::*;
#(
    parameter logic [31:0] DATA_ADDR  = DEF_DATA_ADDR,
    parameter int          FIFO_DEPTH = 16,
    parameter int          MAX_WORDS  = DEF_MAX_WORDS
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [10:0] word_cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,
    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M,
    output logic [3:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,
    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,
    input  logic [3:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M
);
    localparam int          FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [10:0] MAX_W  = 11'(MAX_WORDS);

    rd_state_t         rd_state_q, rd_state_d;
    wr_state_t         wr_state_q, wr_state_d;
    logic [31:0]       rd_addr_q;
    logic [10:0]       rd_left_q, wr_left_q;
    logic [4:0]        blen_q;
    logic              busy_q, done_q, err_q, fin_q;
    logic              start_ok, bad_cnt, r_hs, b_hs, push, pop;
    logic              fifo_full, fifo_empty;
    logic [FCNT_W-1:0] free_cnt;
    logic [31:0]       fifo_head;
    logic [10:0]       bnd_words, blen_w;
    logic              unused_sigs;

    assign start_ok = start && !busy_q;
    assign bad_cnt  = (word_cnt > MAX_W);
    assign r_hs     = RVALID_M && RREADY_M;
    assign b_hs     = BVALID_M && BREADY_M;
    assign push     = r_hs;
    assign pop      = WVALID_M && WREADY_M;

    // Burst length: limited by 16, words left, and the next 4 KB boundary.
    assign bnd_words = 11'd1024 - {1'b0, rd_addr_q[11:2]};
    always_comb begin
        blen_w = (rd_left_q < 11'(MAX_BURST)) ? rd_left_q : 11'(MAX_BURST);
        if (bnd_words < blen_w) blen_w = bnd_words;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (rd_left_q != '0 && 11'(free_cnt) >= blen_w) rd_state_d = R_ADDR;
            R_ADDR:  if (ARREADY_M) rd_state_d = R_DATA;
            R_DATA:  if (RVALID_M && RLAST_M) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Going straight from a B response to the next AW keeps 3 cycles per word.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE: if (!fifo_empty) wr_state_d = W_ADDR;
            W_ADDR: if (AWREADY_M) wr_state_d = W_DATA;
            W_DATA: if (WREADY_M) wr_state_d = W_RESP;
            W_RESP: begin
                if (BVALID_M) begin
                    if (wr_left_q == 11'd1 || fifo_empty) wr_state_d = W_IDLE;
                    else                                   wr_state_d = W_ADDR;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            wr_left_q  <= '0;
            blen_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            done_q     <= 1'b0;
            fin_q      <= 1'b0;
            if (start_ok) begin
                busy_q    <= 1'b1;
                err_q     <= bad_cnt;
                rd_addr_q <= {src_addr[31:2], 2'b00};
                if (bad_cnt || word_cnt == '0) begin
                    rd_left_q <= '0;
                    wr_left_q <= '0;
                    fin_q     <= 1'b1;
                end else begin
                    rd_left_q <= word_cnt;
                    wr_left_q <= word_cnt;
                end
            end
            if (fin_q) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
            if (rd_state_q == R_IDLE && rd_state_d == R_ADDR) blen_q <= blen_w[4:0];
            if (r_hs) begin
                if (RRESP_M != AXI_RESP_OKAY) err_q <= 1'b1;
                if (RLAST_M) begin
                    rd_addr_q <= rd_addr_q + {25'b0, blen_q, 2'b00};
                    rd_left_q <= rd_left_q - {6'b0, blen_q};
                end
            end
            if (b_hs) begin
                if (BRESP_M != AXI_RESP_OKAY) err_q <= 1'b1;
                wr_left_q <= wr_left_q - 11'd1;
                if (wr_left_q == 11'd1) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (AXI_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .push_i     (push),
        .wdata_i    (RDATA_M),
        .pop_i      (pop),
        .rdata_o    (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .free_cnt_o (free_cnt)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ARID_M    = AXI_ID_ZERO;
    assign ARADDR_M  = rd_addr_q;
    assign ARLEN_M   = 4'(blen_q - 5'd1);
    assign ARSIZE_M  = AXI_SIZE_WORD;
    assign ARBURST_M = AXI_BURST_INCR;
    assign ARVALID_M = (rd_state_q == R_ADDR);
    assign RREADY_M  = (rd_state_q == R_DATA);
    assign AWID_M    = AXI_ID_ZERO;
    assign AWADDR_M  = DATA_ADDR;
    assign AWLEN_M   = 4'd0;
    assign AWSIZE_M  = AXI_SIZE_WORD;
    assign AWBURST_M = AXI_BURST_INCR;
    assign AWVALID_M = (wr_state_q == W_ADDR);
    assign WDATA_M   = fifo_head;
    assign WSTRB_M   = AXI_STRB_ALL;
    assign WVALID_M  = (wr_state_q == W_DATA);
    assign WLAST_M   = WVALID_M;
    assign BREADY_M  = (wr_state_q == W_RESP);

    assign unused_sigs = ^{RID_M, BID_M, src_addr[1:0], fifo_full, blen_w[10:5]};
endmodule

// File: tb/tb_asic_dma_feeder.sv
// Directed bench for asic_dma_feeder with reactive AXI memory/register slaves
// and a scoreboard of expected AR bursts and W data.
module tb_asic_dma_feeder;
    logic        ACLK = 1'b0;
    logic        ARESETn, start;
    logic [31:0] src_addr;
    logic [10:0] word_cnt;
    logic        busy, done, err;
    logic [3:0]  ARID_M, ARLEN_M, RID_M, AWID_M, AWLEN_M, WSTRB_M, BID_M;
    logic [31:0] ARADDR_M, RDATA_M, AWADDR_M, WDATA_M;
    logic [2:0]  ARSIZE_M, AWSIZE_M;
    logic [1:0]  ARBURST_M, RRESP_M, AWBURST_M, BRESP_M;
    logic        ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
    logic        AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;

    always #5 ACLK = ~ACLK;

    asic_dma_feeder dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .src_addr(src_addr),
        .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
        .BREADY_M(BREADY_M)
    );

    typedef struct packed {logic [31:0] addr; logic [3:0] len;} ar_t;

    ar_t         exp_ar[$];
    ar_t         act_ar[$];
    logic [31:0] exp_w[$];
    int n_tests = 0, n_fail = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, valid_seen = 0;
    int err_beat = -1;
    bit bp = 1'b0;
    logic last_err = 1'b0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [10:0] n);
        src_addr = a;
        word_cnt = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Expected bursts: min(16, remaining, words to the next 4 KB page).
    task automatic expect_xfer(input logic [31:0] a, input int n);
        logic [31:0] addr;
        int left, bnd, bl;
        ar_t e;
        addr = {a[31:2], 2'b00};
        left = n;
        while (left > 0) begin
            bnd = (4096 - int'(addr[11:0])) / 4;
            bl  = (left < 16) ? left : 16;
            if (bnd < bl) bl = bnd;
            e.addr = addr;
            e.len  = 4'(bl - 1);
            exp_ar.push_back(e);
            for (int i = 0; i < bl; i++) exp_w.push_back(memw(addr + 32'(4 * i)));
            addr = addr + 32'(4 * bl);
            left -= bl;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0, i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 64'(done_cnt), 64'(d0 + 1));
    endtask

    // Slaves: handshakes are judged at the negedge, new drive values at posedge+1.
    initial begin : slaves
        ar_t e, bq;
        logic [35:0] ar_hold;
        logic [32:0] aw_hold, w_hold;
        bit ar_stall, aw_stall, w_stall, r_acc, b_acc, flushed, cur_act;
        int cur_left, b_pend;
        logic [31:0] cur_addr;
        ar_stall = 0; aw_stall = 0; w_stall = 0; cur_act = 0; b_pend = 0; cur_left = 0;
        cur_addr = '0; ar_hold = '0; aw_hold = '0; w_hold = '0;
        ARREADY_M = 0; RVALID_M = 0; AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0;
        RID_M = '0; RDATA_M = '0; RRESP_M = '0; RLAST_M = 0; BID_M = '0; BRESP_M = '0;
        forever begin
            @(negedge ACLK);
            r_acc = 0; b_acc = 0; flushed = 0;
            if (ARVALID_M || AWVALID_M || WVALID_M) valid_seen++;
            if (done === 1'b1) begin
                done_cnt++;
                last_err = err;
            end
            if (ARESETn !== 1'b1) begin
                flushed = 1; cur_act = 0; b_pend = 0; ar_stall = 0; aw_stall = 0; w_stall = 0;
                act_ar.delete(); exp_ar.delete(); exp_w.delete();
                ARREADY_M = 0; RVALID_M = 0; AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0;
            end else begin
                if (ar_stall) chk("ar_stable", 64'({ARVALID_M, ARADDR_M, ARLEN_M}), 64'({1'b1, ar_hold}));
                ar_stall = 0;
                if (ARVALID_M && ARREADY_M) begin
                    ar_cnt++;
                    chk("ar_fixed", 64'({ARID_M, ARSIZE_M, ARBURST_M}), 64'({4'h0, 3'b010, 2'b01}));
                    chk("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
                    if (exp_ar.size() > 0) begin
                        e = exp_ar.pop_front();
                        chk("ar_addr", 64'(ARADDR_M), 64'(e.addr));
                        chk("ar_len", 64'(ARLEN_M), 64'(e.len));
                    end
                    bq.addr = ARADDR_M;
                    bq.len  = ARLEN_M;
                    act_ar.push_back(bq);
                end else if (ARVALID_M) begin
                    ar_stall = 1;
                    ar_hold  = {ARADDR_M, ARLEN_M};
                end
                if (RVALID_M && RREADY_M) begin
                    r_acc = 1;
                    r_cnt++;
                    cur_addr = cur_addr + 32'd4;
                    cur_left--;
                    if (cur_left == 0) cur_act = 0;
                end
                if (aw_stall) chk("aw_stable", 64'({AWVALID_M, AWADDR_M}), 64'(aw_hold));
                aw_stall = 0;
                if (AWVALID_M && AWREADY_M) begin
                    aw_cnt++;
                    chk("aw_fields", 64'({AWADDR_M, AWLEN_M, AWID_M, AWSIZE_M, AWBURST_M}),
                        64'({32'h4, 4'h0, 4'h0, 3'b010, 2'b01}));
                end else if (AWVALID_M) begin
                    aw_stall = 1;
                    aw_hold  = {1'b1, AWADDR_M};
                end
                if (w_stall) chk("w_stable", 64'({WVALID_M, WDATA_M}), 64'(w_hold));
                w_stall = 0;
                if (WVALID_M && WREADY_M) begin
                    w_cnt++;
                    b_pend++;
                    chk("w_last_strb", 64'({WLAST_M, WSTRB_M}), 64'({1'b1, 4'hF}));
                    chk("w_expected", 64'(exp_w.size() > 0), 64'd1);
                    if (exp_w.size() > 0) chk("w_data", 64'(WDATA_M), 64'(exp_w.pop_front()));
                end else if (WVALID_M) begin
                    w_stall = 1;
                    w_hold  = {1'b1, WDATA_M};
                end
                if (BVALID_M && BREADY_M) begin
                    b_acc = 1;
                    b_cnt++;
                    b_pend--;
                end
            end
            @(posedge ACLK);
            #1;
            if (!flushed) begin
                ARREADY_M = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                AWREADY_M = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                WREADY_M  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!(RVALID_M && !r_acc)) begin
                    RVALID_M = 0;
                    if (!cur_act && act_ar.size() > 0) begin
                        bq = act_ar.pop_front();
                        cur_addr = bq.addr;
                        cur_left = int'(bq.len) + 1;
                        cur_act  = 1;
                    end
                    if (cur_act && (!bp || $urandom_range(0, 2) != 0)) begin
                        RVALID_M = 1;
                        RDATA_M  = memw(cur_addr);
                        RLAST_M  = (cur_left == 1);
                        RRESP_M  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
                    end
                end
                if (!(BVALID_M && !b_acc)) begin
                    BVALID_M = 0;
                    if (b_pend > 0 && (!bp || $urandom_range(0, 1) != 0)) BVALID_M = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0, w0, b0, v0, d0, r0, k;
        ARESETn = 1'b0; start = 1'b0; src_addr = '0; word_cnt = '0;
        repeat (3) tick();
        chk("reset_outputs", 64'({busy, done, err, ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M}), 64'd0);
        ARESETn = 1'b1;
        tick();

        // Full image, zero-wait slaves.
        a0 = ar_cnt; w0 = w_cnt; b0 = b_cnt; d0 = done_cnt;
        expect_xfer(32'h1000, 1104);
        do_start(32'h1000, 11'd1104);
        chk("full_busy", 64'(busy), 64'd1);
        wait_done("full_done", 6000);
        repeat (5) tick();
        chk("full_bursts", 64'(ar_cnt - a0), 64'd69);
        chk("full_writes", 64'(w_cnt - w0), 64'd1104);
        chk("full_bresps", 64'(b_cnt - b0), 64'd1104);
        chk("full_done_once", 64'(done_cnt - d0), 64'd1);
        chk("full_err", 64'(last_err), 64'd0);
        chk("full_sb_empty", 64'(exp_w.size() + exp_ar.size()), 64'd0);

        // 4 KB boundary split: ARLEN 3 then 15.
        a0 = ar_cnt; w0 = w_cnt;
        expect_xfer(32'h1FF0, 20);
        do_start(32'h1FF0, 11'd20);
        wait_done("split_done", 400);
        chk("split_bursts", 64'(ar_cnt - a0), 64'd2);
        chk("split_writes", 64'(w_cnt - w0), 64'd20);
        chk("split_sb_empty", 64'(exp_w.size() + exp_ar.size()), 64'd0);

        // Random backpressure on every slave channel.
        bp = 1'b1;
        w0 = w_cnt; b0 = b_cnt;
        expect_xfer(32'h4FC8, 37);
        do_start(32'h4FC8, 11'd37);
        wait_done("bp_done", 3000);
        chk("bp_bresps", 64'(b_cnt - b0), 64'd37);
        chk("bp_writes", 64'(w_cnt - w0), 64'd37);
        chk("bp_sb_empty", 64'(exp_w.size() + exp_ar.size()), 64'd0);
        bp = 1'b0;
        tick();

        // SLVERR on the fifth read beat.
        w0 = w_cnt;
        err_beat = r_cnt + 4;
        expect_xfer(32'h0200, 8);
        do_start(32'h0200, 11'd8);
        wait_done("rerr_done", 400);
        chk("rerr_err_at_done", 64'(last_err), 64'd1);
        chk("rerr_writes", 64'(w_cnt - w0), 64'd8);
        err_beat = -1;
        tick();
        chk("rerr_err_sticky", 64'(err), 64'd1);
        expect_xfer(32'h0300, 2);
        do_start(32'h0300, 11'd2);
        chk("rerr_cleared", 64'(err), 64'd0);
        wait_done("clean_done", 200);
        chk("clean_err", 64'(last_err), 64'd0);

        // Zero-length transfer.
        v0 = valid_seen; d0 = done_cnt;
        do_start(32'h0400, 11'd0);
        chk("zero_busy_done", 64'({busy, done}), 64'({1'b1, 1'b0}));
        tick();
        chk("zero_done_pulse", 64'({busy, done, err}), 64'({1'b0, 1'b1, 1'b0}));
        tick();
        chk("zero_done_drop", 64'(done), 64'd0);
        chk("zero_no_traffic", 64'(valid_seen - v0), 64'd0);

        // Oversized count.
        v0 = valid_seen;
        do_start(32'h0400, 11'd1200);
        chk("big_err", 64'({busy, done, err}), 64'({1'b1, 1'b0, 1'b1}));
        tick();
        chk("big_done", 64'({busy, done, err}), 64'({1'b0, 1'b1, 1'b1}));
        repeat (3) tick();
        chk("big_no_traffic", 64'(valid_seen - v0), 64'd0);

        // Start while busy is ignored.
        a0 = ar_cnt; w0 = w_cnt;
        expect_xfer(32'h7000, 4);
        do_start(32'h7000, 11'd4);
        tick();
        do_start(32'h9000, 11'd100);
        wait_done("ign_done", 300);
        repeat (20) tick();
        chk("ign_bursts", 64'(ar_cnt - a0), 64'd1);
        chk("ign_writes", 64'(w_cnt - w0), 64'd4);
        chk("ign_idle", 64'(busy), 64'd0);

        // Reset mid-burst at word 10 of 16, then a clean transfer.
        r0 = r_cnt;
        expect_xfer(32'h3000, 16);
        do_start(32'h3000, 11'd16);
        k = 0;
        while (r_cnt - r0 < 10 && k < 200) begin
            tick();
            k++;
        end
        chk("rst_reached_beat10", 64'(r_cnt - r0), 64'd10);
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        chk("rst_outputs", 64'({busy, done, err, ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M}), 64'd0);
        repeat (2) tick();
        w0 = w_cnt;
        expect_xfer(32'h6000, 5);
        do_start(32'h6000, 11'd5);
        wait_done("post_rst_done", 300);
        chk("post_rst_writes", 64'(w_cnt - w0), 64'd5);
        chk("post_rst_err", 64'(last_err), 64'd0);
        chk("post_rst_sb_empty", 64'(exp_w.size() + exp_ar.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
